// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: FSM states, opcodes
// and the next-PC / writeback source selects.
package multicycle_control_unit_pkg;

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMem       = 3'd3,
    StWriteback = 3'd4,
    StTrap      = 3'd5
  } state_e;

  localparam logic [6:0] OpcR     = 7'b0110011;
  localparam logic [6:0] OpcI     = 7'b0010011;
  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;
  localparam logic [6:0] OpcBr    = 7'b1100011;
  localparam logic [6:0] OpcJal   = 7'b1101111;
  localparam logic [6:0] OpcJalr  = 7'b1100111;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  localparam logic [1:0] PcSelPlus4  = 2'd0;
  localparam logic [1:0] PcSelBranch = 2'd1;
  localparam logic [1:0] PcSelJalr   = 2'd2;

  localparam logic [1:0] WbSelAlu = 2'd0;
  localparam logic [1:0] WbSelMem = 2'd1;
  localparam logic [1:0] WbSelPc4 = 2'd2;
  localparam logic [1:0] WbSelImm = 2'd3;

endpackage

// File: rtl/multicycle_control_unit_opcode_classifier.sv
// Combinational classification of the latched opcode into instruction classes
// and the writeback source it needs.
module multicycle_control_unit_opcode_classifier
  import multicycle_control_unit_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       is_legal_o,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_branch_o,
  output logic       is_jal_o,
  output logic       is_jalr_o,
  output logic [1:0] wb_sel_o
);

  always_comb begin
    is_legal_o  = 1'b1;
    is_load_o   = 1'b0;
    is_store_o  = 1'b0;
    is_branch_o = 1'b0;
    is_jal_o    = 1'b0;
    is_jalr_o   = 1'b0;
    wb_sel_o    = WbSelAlu;
    case (opcode_i)
      OpcR, OpcI, OpcAuipc: ;  // AUIPC adds PC in the ALU, so ALU writeback
      OpcLoad: begin
        is_load_o = 1'b1;
        wb_sel_o  = WbSelMem;
      end
      OpcStore: is_store_o  = 1'b1;
      OpcBr:    is_branch_o = 1'b1;
      OpcJal: begin
        is_jal_o = 1'b1;
        wb_sel_o = WbSelPc4;
      end
      OpcJalr: begin
        is_jalr_o = 1'b1;
        wb_sel_o  = WbSelPc4;
      end
      OpcLui:  wb_sel_o   = WbSelImm;
      default: is_legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the RV32I
// core, with retired-instruction counter and sticky illegal-opcode trap.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr,
  output logic                 imem_req,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  input  logic                 branch_taken,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 illegal_instr,
  output logic [CNT_WIDTH-1:0] retired_cnt,
  output logic [2:0]           state_dbg
);

  state_e               state_q, state_d;
  logic [6:0]           opcode_q;
  logic [2:0]           funct3_q;
  logic [4:0]           rd_q;
  logic                 illegal_q;
  logic [CNT_WIDTH-1:0] retired_q;

  logic       is_legal, is_load, is_store, is_branch, is_jal, is_jalr;
  logic [1:0] cls_wb_sel;

  logic imem_req_c, ir_we_c, pc_we_c, rf_we_c, dmem_req_c, dmem_we_c, retire;

  multicycle_control_unit_opcode_classifier u_classifier (
    .opcode_i    (opcode_q),
    .is_legal_o  (is_legal),
    .is_load_o   (is_load),
    .is_store_o  (is_store),
    .is_branch_o (is_branch),
    .is_jal_o    (is_jal),
    .is_jalr_o   (is_jalr),
    .wb_sel_o    (cls_wb_sel)
  );

  always_comb begin
    state_d    = state_q;
    imem_req_c = 1'b0;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    pc_sel     = PcSelPlus4;
    rf_we_c    = 1'b0;
    wb_sel     = WbSelAlu;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    retire     = 1'b0;
    case (state_q)
      StFetch: begin
        imem_req_c = 1'b1;
        if (imem_ack) begin
          ir_we_c = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: state_d = is_legal ? StExecute : StTrap;
      StExecute: begin
        if (is_branch) begin
          pc_we_c = 1'b1;
          pc_sel  = branch_taken ? PcSelBranch : PcSelPlus4;
          retire  = 1'b1;
          state_d = StFetch;
        end else if (is_load || is_store) begin
          state_d = StMem;
        end else begin
          state_d = StWriteback;
        end
      end
      StMem: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_store;
        if (dmem_ack) begin
          if (is_store) begin
            pc_we_c = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWriteback;
          end
        end
      end
      StWriteback: begin
        rf_we_c = (rd_q != 5'd0);
        wb_sel  = cls_wb_sel;
        pc_we_c = 1'b1;
        pc_sel  = is_jal ? PcSelBranch : (is_jalr ? PcSelJalr : PcSelPlus4);
        retire  = 1'b1;
        state_d = StFetch;
      end
      StTrap:  ;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      opcode_q  <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (ir_we_c) begin
        opcode_q <= instr[6:0];
        funct3_q <= instr[14:12];
        rd_q     <= instr[11:7];
      end
      if (state_q == StDecode && !is_legal) illegal_q <= 1'b1;
      if (retire) retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  // Reset asserts FETCH asynchronously; gating keeps every strobe low meanwhile.
  assign imem_req      = rst_n & imem_req_c;
  assign ir_we         = rst_n & ir_we_c;
  assign pc_we         = rst_n & pc_we_c;
  assign rf_we         = rst_n & rf_we_c;
  assign dmem_req      = rst_n & dmem_req_c;
  assign dmem_we       = rst_n & dmem_we_c;
  assign illegal_instr = illegal_q;
  assign retired_cnt   = retired_q;
  assign state_dbg     = state_q;

  // funct3 is latched for downstream debug; PC_WIDTH sizes nothing here.
  logic                unused_bits;
  logic [PC_WIDTH-1:0] unused_pc;
  assign unused_bits = ^{funct3_q, instr[31:15]};
  assign unused_pc   = '0;

endmodule
